quad_add_sequencer: RTL and testbench
=====================================

QUAD_ADD_SEQUENCER -- requirements
Module: quad_add_sequencer

Interface
REQ-001 Parameter SDATA_WIDTH, default 256, input and output beat width in bits.
REQ-002 Parameter SSAMPLE_WIDTH, default 16, lane-sample width; SDATA_WIDTH SHALL be an integer multiple of it.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, collect-phase timeout in clock cycles (range 1..65535).
REQ-004 Port clock, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port resetn, input, 1, asynchronous active-low reset.
REQ-006 Ports sXX_axis_tdata, input, SDATA_WIDTH, input beat for XX in {00,01,20,21}.
REQ-007 Ports sXX_axis_tvalid, input, 1, input beat valid.
REQ-008 Ports sXX_axis_tready, output, 1, input beat accept.
REQ-009 Ports sXX_axis_tlast, input, 1, frame-end marker of input beat.
REQ-010 Port lane_enable, input, 4, bit 0..3 = s00, s01, s20, s21 participates; sampled only in IDLE.
REQ-011 Port m_axis_tdata, output, SDATA_WIDTH, lane-wise sum.
REQ-012 Port m_axis_tvalid, output, 1, output beat valid.
REQ-013 Port m_axis_tready, input, 1, downstream accept.
REQ-014 Port m_axis_tlast, output, 1, OR of tlast of captured beats.
REQ-015 Port m_axis_tuser, output, 4, mask of lanes contributing to current output beat.
REQ-016 Port timeout_flag, output, 1, sticky: a partial beat was emitted since reset.

Function
REQ-017 FSM states IDLE, COLLECT, EMIT; reset state IDLE.
REQ-018 IDLE: register active_mask <= lane_enable; if lane_enable == 0 remain IDLE, else go COLLECT next cycle; all sXX_axis_tready = 0.
REQ-019 COLLECT: sXX_axis_tready = active_mask[k] AND NOT captured[k], combinational from registered state only.
REQ-020 COLLECT: on tvalid&&tready for lane k, capture tdata/tlast into holding register k and set captured[k]; any number of lanes may capture in one cycle.
REQ-021 COLLECT -> EMIT in the cycle after (captured | this-cycle handshakes) == active_mask; latency last capture to m_axis_tvalid = 1 cycle.
REQ-022 Disabled or uncaptured lanes contribute zero; each lane never accepts more than one beat per frame.
REQ-023 EMIT: m_axis_tvalid = 1; m_axis_tdata sample i = sum over captured lanes of sample i, modulo 2^SSAMPLE_WIDTH (wraps, no saturation, no carry between samples).
REQ-024 EMIT: m_axis_tdata/tlast/tuser held stable while m_axis_tvalid && !m_axis_tready; all sXX_axis_tready = 0.
REQ-025 EMIT: on m_axis_tready go IDLE next cycle, clear captured, m_axis_tvalid = 0 in IDLE; minimum frame period 3 cycles.
REQ-026 lane_enable changes outside IDLE SHALL have no effect on the current frame.
REQ-027 m_axis_tdata SHALL be 0 whenever m_axis_tvalid = 0.

Reset
REQ-028 resetn low asynchronously forces state IDLE, captured = 0, active_mask = 0, holding registers = 0, counter = 0, timeout_flag = 0.
REQ-029 During reset all sXX_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata = 0.
REQ-030 Reset asserted in COLLECT or EMIT discards the frame; no beat emitted after release until a new frame completes.

Configuration
REQ-031 Macro QUAD_ADD_SEQ_TIMEOUT_EN defined: counter increments each COLLECT cycle, cleared on entry; at count == TIMEOUT_CYCLES with frame incomplete, go EMIT with captured lanes only, tuser = captured (may be 0, data 0), set timeout_flag.
REQ-032 Completion and timeout in same cycle: completion wins, timeout_flag unchanged.
REQ-033 Macro undefined: no counter logic, COLLECT waits indefinitely, timeout_flag tied 0.

Verification
REQ-034 lane_enable=4'hF, all lanes valid same cycle, every sample 16'h0001 -> one beat, every sample 16'h0004, tuser=4'hF, tvalid one cycle after capture.
REQ-035 lane_enable=4'b0101, s00 samples 16'h8000, s20 samples 16'h8001 -> samples 16'h0001 (wrap), tuser=4'b0101, s01/s21 tready stay 0.
REQ-036 Full frame, m_axis_tready low 10 cycles -> output stable 10 cycles, all sXX tready 0, single transfer on tready.
REQ-037 QUAD_ADD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, only s00 sends 16'h0007 -> after 8 COLLECT cycles beat 16'h0007 per sample, tuser=4'b0001, timeout_flag=1.
REQ-038 resetn pulsed low mid-COLLECT with two lanes captured -> all outputs 0 immediately, no output beat after release until a fresh full frame.

Source files
------------

// File: rtl/quad_add_sequencer.sv
// Four-input AXI-Stream lane-wise adder: collects one beat per enabled lane, then emits their per-sample sum.
// Optional collect-phase timeout is enabled by defining QUAD_ADD_SEQ_TIMEOUT_EN.
module quad_add_sequencer #(
    parameter int SDATA_WIDTH    = 256,
    parameter int SSAMPLE_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [SDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                   s00_axis_tvalid,
    output logic                   s00_axis_tready,
    input  logic                   s00_axis_tlast,
    input  logic [SDATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                   s01_axis_tvalid,
    output logic                   s01_axis_tready,
    input  logic                   s01_axis_tlast,
    input  logic [SDATA_WIDTH-1:0] s20_axis_tdata,
    input  logic                   s20_axis_tvalid,
    output logic                   s20_axis_tready,
    input  logic                   s20_axis_tlast,
    input  logic [SDATA_WIDTH-1:0] s21_axis_tdata,
    input  logic                   s21_axis_tvalid,
    output logic                   s21_axis_tready,
    input  logic                   s21_axis_tlast,
    input  logic [3:0]             lane_enable,
    output logic [SDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [3:0]             m_axis_tuser,
    output logic                   timeout_flag
);
    localparam int NSAMP = SDATA_WIDTH / SSAMPLE_WIDTH;

    if ((SDATA_WIDTH % SSAMPLE_WIDTH) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("quad_add_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, EMIT = 2'd2} state_t;

    state_t                 state_r, state_s;
    logic [3:0]             active_r, captured_r, hold_last_r;
    logic [SDATA_WIDTH-1:0] hold_r [4];
    logic [SDATA_WIDTH-1:0] in_data_s [4];
    logic [SDATA_WIDTH-1:0] lane_val_s [4];
    logic [3:0]             valid_s, last_in_s, last_val_s, ready_s, hs_s, cap_next_s;
    logic                   done_s, timeout_s;
    logic [SDATA_WIDTH-1:0] out_data_r;
    logic                   out_last_r;
    logic [3:0]             out_user_r;

    // Per-sample modular sum of the masked lanes; samples never carry into each other.
    function automatic logic [SDATA_WIDTH-1:0] lane_sum(
        input logic [SDATA_WIDTH-1:0] v0, v1, v2, v3,
        input logic [3:0]             m
    );
        logic [SSAMPLE_WIDTH-1:0] acc;
        lane_sum = '0;
        for (int i = 0; i < NSAMP; i++) begin
            acc = (v0[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] & {SSAMPLE_WIDTH{m[0]}})
                + (v1[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] & {SSAMPLE_WIDTH{m[1]}})
                + (v2[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] & {SSAMPLE_WIDTH{m[2]}})
                + (v3[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] & {SSAMPLE_WIDTH{m[3]}});
            lane_sum[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] = acc;
        end
    endfunction

    assign in_data_s[0] = s00_axis_tdata;
    assign in_data_s[1] = s01_axis_tdata;
    assign in_data_s[2] = s20_axis_tdata;
    assign in_data_s[3] = s21_axis_tdata;
    assign valid_s      = {s21_axis_tvalid, s20_axis_tvalid, s01_axis_tvalid, s00_axis_tvalid};
    assign last_in_s    = {s21_axis_tlast, s20_axis_tlast, s01_axis_tlast, s00_axis_tlast};

    // Lane accept and completion, derived from registered state only.
    always_comb begin
        ready_s = 4'b0000;
        if (state_r == COLLECT) begin
            ready_s = active_r & ~captured_r;
        end else begin
            ready_s = 4'b0000;
        end
        hs_s       = ready_s & valid_s;
        cap_next_s = captured_r | hs_s;
        done_s     = (state_r == COLLECT) && (cap_next_s == active_r);
    end

    // Value each lane contributes if the frame closes this cycle.
    always_comb begin
        last_val_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            lane_val_s[k] = '0;
            if (hs_s[k]) begin
                lane_val_s[k] = in_data_s[k];
                last_val_s[k] = last_in_s[k];
            end else begin
                lane_val_s[k] = hold_r[k];
                last_val_s[k] = hold_last_r[k];
            end
        end
    end

    assign s00_axis_tready = ready_s[0];
    assign s01_axis_tready = ready_s[1];
    assign s20_axis_tready = ready_s[2];
    assign s21_axis_tready = ready_s[3];

`ifdef QUAD_ADD_SEQ_TIMEOUT_EN
    logic [15:0] cnt_r;
    logic        timeout_flag_r;

    assign timeout_s = (state_r == COLLECT) && (cnt_r == 16'(TIMEOUT_CYCLES - 1));

    // Collect-phase cycle counter, restarted on every COLLECT entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= 16'd0;
        end else if (state_r == COLLECT) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= 16'd0;
        end
    end

    // Sticky flag: only a timeout that actually truncates the frame sets it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timeout_flag_r <= 1'b0;
        end else if (timeout_s && !done_s) begin
            timeout_flag_r <= 1'b1;
        end else begin
            timeout_flag_r <= timeout_flag_r;
        end
    end

    assign timeout_flag = timeout_flag_r;
`else
    assign timeout_s    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (lane_enable != 4'b0000) state_s = COLLECT;
                else                        state_s = IDLE;
            end
            COLLECT: begin
                if (done_s || timeout_s) state_s = EMIT;
                else                     state_s = COLLECT;
            end
            EMIT: begin
                if (m_axis_tready) state_s = IDLE;
                else               state_s = EMIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Lane mask latch (IDLE only) plus capture bookkeeping and holding registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            active_r    <= 4'b0000;
            captured_r  <= 4'b0000;
            hold_last_r <= 4'b0000;
            for (int k = 0; k < 4; k++) hold_r[k] <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    active_r   <= lane_enable;
                    captured_r <= 4'b0000;
                end
                COLLECT: begin
                    captured_r <= cap_next_s;
                    for (int k = 0; k < 4; k++) begin
                        if (hs_s[k]) begin
                            hold_r[k]      <= in_data_s[k];
                            hold_last_r[k] <= last_in_s[k];
                        end
                    end
                end
                EMIT: begin
                    if (m_axis_tready) captured_r <= 4'b0000;
                end
                default: captured_r <= 4'b0000;
            endcase
        end
    end

    // Output beat: loaded as the frame closes, held through back-pressure, zeroed after transfer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_data_r <= '0;
            out_last_r <= 1'b0;
            out_user_r <= 4'b0000;
        end else if (state_r == COLLECT && (done_s || timeout_s)) begin
            out_data_r <= lane_sum(lane_val_s[0], lane_val_s[1], lane_val_s[2], lane_val_s[3], cap_next_s);
            out_last_r <= |(cap_next_s & last_val_s);
            out_user_r <= cap_next_s;
        end else if (state_r == EMIT && m_axis_tready) begin
            out_data_r <= '0;
            out_last_r <= 1'b0;
            out_user_r <= 4'b0000;
        end else begin
            out_data_r <= out_data_r;
            out_last_r <= out_last_r;
            out_user_r <= out_user_r;
        end
    end

    assign m_axis_tvalid = (state_r == EMIT);
    assign m_axis_tdata  = out_data_r;
    assign m_axis_tlast  = out_last_r;
    assign m_axis_tuser  = out_user_r;
endmodule

// File: tb/tb_quad_add_sequencer.sv
// Directed self-checking bench for quad_add_sequencer (default 256-bit beats, 16-bit samples, timeout 8).
module tb_quad_add_sequencer;
    logic         clock = 1'b0;
    logic         resetn;
    logic [255:0] s00_tdata, s01_tdata, s20_tdata, s21_tdata;
    logic         s00_tvalid, s01_tvalid, s20_tvalid, s21_tvalid;
    logic         s00_tready, s01_tready, s20_tready, s21_tready;
    logic         s00_tlast, s01_tlast, s20_tlast, s21_tlast;
    logic [3:0]   lane_enable;
    logic [255:0] m_tdata;
    logic         m_tvalid, m_tready, m_tlast;
    logic [3:0]   m_tuser;
    logic         timeout_flag;
    logic [3:0]   rdy;
    int           total = 0;
    int           bad = 0;

    quad_add_sequencer #(.SDATA_WIDTH(256), .SSAMPLE_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .resetn(resetn),
        .s00_axis_tdata(s00_tdata), .s00_axis_tvalid(s00_tvalid), .s00_axis_tready(s00_tready), .s00_axis_tlast(s00_tlast),
        .s01_axis_tdata(s01_tdata), .s01_axis_tvalid(s01_tvalid), .s01_axis_tready(s01_tready), .s01_axis_tlast(s01_tlast),
        .s20_axis_tdata(s20_tdata), .s20_axis_tvalid(s20_tvalid), .s20_axis_tready(s20_tready), .s20_axis_tlast(s20_tlast),
        .s21_axis_tdata(s21_tdata), .s21_axis_tvalid(s21_tvalid), .s21_axis_tready(s21_tready), .s21_axis_tlast(s21_tlast),
        .lane_enable(lane_enable),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .timeout_flag(timeout_flag)
    );

    always #5 clock = ~clock;
    assign rdy = {s21_tready, s20_tready, s01_tready, s00_tready};

    function automatic logic [255:0] rep(input logic [15:0] v);
        return {16{v}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_tvalid"}, 256'(m_tvalid), 256'd0);
        chk({tag, "_tdata"}, m_tdata, 256'd0);
        chk({tag, "_rdy"}, 256'(rdy), 256'd0);
    endtask

    initial begin
        resetn = 1'b0; lane_enable = 4'b0000; m_tready = 1'b1;
        s00_tdata = '0; s01_tdata = '0; s20_tdata = '0; s21_tdata = '0;
        {s00_tvalid, s01_tvalid, s20_tvalid, s21_tvalid} = 4'b0000;
        {s00_tlast, s01_tlast, s20_tlast, s21_tlast} = 4'b0000;
        repeat (3) tick();
        idle_outputs("reset");
        chk("reset_tuser", 256'(m_tuser), 256'd0);
        chk("reset_tlast", 256'(m_tlast), 256'd0);
        chk("reset_flag", 256'(timeout_flag), 256'd0);
        resetn = 1'b1;
        tick();

        // All four lanes in one cycle, every sample 1 -> 4.
        lane_enable = 4'hF;
        tick();
        chk("t1_rdy", 256'(rdy), 256'hF);
        lane_enable = 4'h0;
        s00_tdata = rep(16'h0001); s01_tdata = rep(16'h0001); s20_tdata = rep(16'h0001); s21_tdata = rep(16'h0001);
        {s00_tvalid, s01_tvalid, s20_tvalid, s21_tvalid} = 4'b1111;
        s21_tlast = 1'b1;
        chk("t1_novalid_yet", 256'(m_tvalid), 256'd0);
        tick();
        {s00_tvalid, s01_tvalid, s20_tvalid, s21_tvalid} = 4'b0000;
        s21_tlast = 1'b0;
        chk("t1_tvalid", 256'(m_tvalid), 256'd1);
        chk("t1_tdata", m_tdata, rep(16'h0004));
        chk("t1_tuser", 256'(m_tuser), 256'hF);
        chk("t1_tlast", 256'(m_tlast), 256'd1);
        chk("t1_rdy_emit", 256'(rdy), 256'd0);
        tick();
        idle_outputs("t1_after");

        // Lanes 0 and 2 with wrap; staggered arrivals; disabled lanes offer junk.
        lane_enable = 4'b0101;
        tick();
        chk("t2_rdy0", 256'(rdy), 256'b0101);
        lane_enable = 4'hF;
        s00_tdata = rep(16'h8000); s00_tvalid = 1'b1;
        s01_tdata = rep(16'h1234); s01_tvalid = 1'b1;
        s21_tdata = rep(16'h4321); s21_tvalid = 1'b1;
        tick();
        chk("t2_rdy1", 256'(rdy), 256'b0100);
        chk("t2_wait", 256'(m_tvalid), 256'd0);
        s00_tvalid = 1'b0;
        s20_tdata = rep(16'h8001); s20_tvalid = 1'b1;
        tick();
        s20_tvalid = 1'b0; s01_tvalid = 1'b0; s21_tvalid = 1'b0;
        lane_enable = 4'h0;
        chk("t2_tvalid", 256'(m_tvalid), 256'd1);
        chk("t2_tdata", m_tdata, rep(16'h0001));
        chk("t2_tuser", 256'(m_tuser), 256'b0101);
        chk("t2_tlast", 256'(m_tlast), 256'd0);
        tick();
        idle_outputs("t2_after");

        // Back-pressure for 10 cycles; sum 1+2+3+FFFF wraps to 5.
        m_tready = 1'b0;
        lane_enable = 4'hF;
        tick();
        lane_enable = 4'h0;
        s00_tdata = rep(16'h0001); s01_tdata = rep(16'h0002); s20_tdata = rep(16'h0003); s21_tdata = rep(16'hFFFF);
        {s00_tvalid, s01_tvalid, s20_tvalid, s21_tvalid} = 4'b1111;
        s00_tlast = 1'b1;
        tick();
        {s00_tvalid, s01_tvalid, s20_tvalid, s21_tvalid} = 4'b0000;
        s00_tlast = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_tvalid", 256'(m_tvalid), 256'd1);
            chk("t3_hold_tdata", m_tdata, rep(16'h0005));
            chk("t3_hold_tuser", 256'(m_tuser), 256'hF);
            chk("t3_hold_tlast", 256'(m_tlast), 256'd1);
            chk("t3_hold_rdy", 256'(rdy), 256'd0);
            tick();
        end
        m_tready = 1'b1;
        tick();
        idle_outputs("t3_xfer");
        tick();
        idle_outputs("t3_single");

        // Reset mid-COLLECT with two lanes captured discards the frame.
        lane_enable = 4'hF;
        tick();
        lane_enable = 4'h0;
        s00_tdata = rep(16'h0055); s01_tdata = rep(16'h0066);
        s00_tvalid = 1'b1; s01_tvalid = 1'b1;
        tick();
        s00_tvalid = 1'b0; s01_tvalid = 1'b0;
        chk("t4_rdy_partial", 256'(rdy), 256'b1100);
        resetn = 1'b0;
        #1;
        idle_outputs("t4_in_reset");
        chk("t4_in_reset_tuser", 256'(m_tuser), 256'd0);
        tick();
        resetn = 1'b1;
        s20_tvalid = 1'b1; s21_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle_outputs("t4_post_reset");
            tick();
        end
        s20_tvalid = 1'b0; s21_tvalid = 1'b0;
        lane_enable = 4'b0011;
        tick();
        lane_enable = 4'h0;
        s00_tdata = rep(16'h0010); s01_tdata = rep(16'h0020);
        s00_tvalid = 1'b1; s01_tvalid = 1'b1;
        tick();
        s00_tvalid = 1'b0; s01_tvalid = 1'b0;
        chk("t4_fresh_tvalid", 256'(m_tvalid), 256'd1);
        chk("t4_fresh_tdata", m_tdata, rep(16'h0030));
        chk("t4_fresh_tuser", 256'(m_tuser), 256'b0011);
        tick();

        // Incomplete frame: only s00 delivers.
        lane_enable = 4'hF;
        tick();
        lane_enable = 4'h0;
        s00_tdata = rep(16'h0007); s00_tvalid = 1'b1;
        tick();
        s00_tvalid = 1'b0;
`ifdef QUAD_ADD_SEQ_TIMEOUT_EN
        for (int i = 2; i <= 8; i++) begin
            chk("t5_before_timeout", 256'(m_tvalid), 256'd0);
            tick();
        end
        chk("t5_tvalid", 256'(m_tvalid), 256'd1);
        chk("t5_tdata", m_tdata, rep(16'h0007));
        chk("t5_tuser", 256'(m_tuser), 256'b0001);
        chk("t5_flag", 256'(timeout_flag), 256'd1);
        tick();
        chk("t5_flag_sticky", 256'(timeout_flag), 256'd1);
        idle_outputs("t5_after");
`else
        repeat (20) tick();
        chk("t5_wait_tvalid", 256'(m_tvalid), 256'd0);
        chk("t5_wait_rdy", 256'(rdy), 256'b1110);
        chk("t5_flag", 256'(timeout_flag), 256'd0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        idle_outputs("t5_after");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
